// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: FSM encoding, result-source and funct3 size codes.
package mem_wb_stage_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    typedef struct packed {
        logic        regWrite;
        logic [1:0]  resultSrc;
        logic [31:0] aluResult;
        logic [31:0] readData;
        logic [4:0]  rd;
        logic [31:0] pcPlus4;
    } wb_bundle_t;

    // A store wins over a load when both flags are set.
    function automatic logic isLoadOp(input logic memWrite, input logic [1:0] resultSrc);
        return !memWrite && (resultSrc == RESULT_LOAD);
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_store_align.sv
// Byte-enable generation, store-lane replication and load sign/zero extension
// for sub-word accesses (used only when SUBWORD_ACCESS_EN is defined).
module load_store_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLow,
    input  logic [31:0] storeData,
    input  logic [31:0] loadData,
    output logic [3:0]  byteEn,
    output logic [31:0] storeLanes,
    output logic [31:0] loadExt
);

    logic [7:0]  lane [4];
    logic [7:0]  selByte;
    logic [15:0] selHalf;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = loadData[8*gi +: 8];
        end
    endgenerate

    assign selByte = lane[addrLow];
    assign selHalf = addrLow[1] ? loadData[31:16] : loadData[15:0];

    always_comb begin
        byteEn     = 4'b1111;
        storeLanes = storeData;
        loadExt    = loadData;
        case (funct3)
            F3_BYTE: begin
                byteEn     = 4'b0001 << addrLow;
                storeLanes = {4{storeData[7:0]}};
                loadExt    = {{24{selByte[7]}}, selByte};
            end
            F3_HALF: begin
                byteEn     = 4'b0011 << addrLow;
                storeLanes = {2{storeData[15:0]}};
                loadExt    = {{16{selHalf[15]}}, selHalf};
            end
            F3_BYTE_U: begin
                byteEn  = 4'b0001 << addrLow;
                loadExt = {24'b0, selByte};
            end
            F3_HALF_U: begin
                byteEn  = 4'b0011 << addrLow;
                loadExt = {16'b0, selHalf};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage with a req/gnt/rvalid data-memory handshake and stall generation.
// Optional sub-word accesses are enabled by defining SUBWORD_ACCESS_EN.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W
);

    logic [1:0]  stateReg, stateNext;
    wb_bundle_t  wbReg, wbNext;
    logic        isStore, isLoad, pending;
    logic [3:0]  beSel;
    logic [31:0] wdataSel, loadExt;

    assign isStore = MemWriteM;
    assign isLoad  = isLoadOp(MemWriteM, ResultSrcM);
    assign pending = isStore || isLoad;

`ifdef SUBWORD_ACCESS_EN
    load_store_align u_align (
        .funct3     (Funct3M),
        .addrLow    (ALUResultM[1:0]),
        .storeData  (WriteDataM),
        .loadData   (dmem_rdata),
        .byteEn     (beSel),
        .storeLanes (wdataSel),
        .loadExt    (loadExt)
    );
`else
    logic unusedBits;
    assign unusedBits = ^{Funct3M, ALUResultM[1:0]};
    assign beSel      = 4'b1111;
    assign wdataSel   = WriteDataM;
    assign loadExt    = dmem_rdata;
`endif

    // Request fields come straight from the M inputs, which the pipeline holds while stalled.
    assign dmem_req   = !rst && (((stateReg == ST_IDLE) && pending) || (stateReg == ST_REQ));
    assign dmem_we    = dmem_req && isStore;
    assign dmem_addr  = {ALUResultM[31:2], 2'b00};
    assign dmem_wdata = wdataSel;
    assign dmem_be    = beSel;

    always_comb begin
        stateNext = stateReg;
        StallM    = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                if (pending) begin
                    if (!dmem_gnt) begin
                        stateNext = ST_REQ;
                        StallM    = 1'b1;
                    end else if (!isStore) begin
                        stateNext = ST_RESP;
                        StallM    = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                StallM = 1'b1;
                if (dmem_gnt) begin
                    if (isStore) begin
                        stateNext = ST_IDLE;
                        StallM    = 1'b0;
                    end else begin
                        stateNext = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (dmem_rvalid) stateNext = ST_IDLE;
                else             StallM    = 1'b1;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // A stalled cycle hands a bubble to writeback.
    always_comb begin
        wbNext = '0;
        if (!StallM) begin
            wbNext.regWrite  = RegWriteM;
            wbNext.resultSrc = ResultSrcM;
            wbNext.aluResult = ALUResultM;
            wbNext.readData  = isLoad ? loadExt : 32'b0;
            wbNext.rd        = RdM;
            wbNext.pcPlus4   = PCPlus4M;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= ST_IDLE;
            wbReg    <= '0;
        end else begin
            stateReg <= stateNext;
            wbReg    <= wbNext;
        end
    end

    assign RegWriteW  = wbReg.regWrite;
    assign ResultSrcW = wbReg.resultSrc;
    assign ALUResultW = wbReg.aluResult;
    assign ReadDataW  = wbReg.readData;
    assign RdW        = wbReg.rd;
    assign PCPlus4W   = wbReg.pcPlus4;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: per-instruction handshake schedules drive a
// transaction-level model; one compare process checks the DUT every cycle.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        StallM, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
    );

    int total = 0;
    int bad   = 0;
    int stallSeen = 0;
    int reqSeen   = 0;
    logic [3:0] lastBe = 4'b0;
    logic checkEn  = 1'b0;
    logic expStall = 1'b0;
    logic expReq   = 1'b0;

    // Model of the writeback registers
    logic        mRegWrite;
    logic [1:0]  mResultSrc;
    logic [31:0] mAlu, mRead, mPc;
    logic [4:0]  mRd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdlLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
`ifdef SUBWORD_ACCESS_EN
        int sh;
        logic [31:0] w;
        sh = 8 * int'(addr[1:0]);
        w  = rdata >> sh;
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'b0, w[7:0]};
            3'b101:  return {16'b0, w[15:0]};
            default: return rdata;
        endcase
`else
        return rdata;
`endif
    endfunction

    function automatic logic [3:0] mdlBe(input logic [2:0] f3, input logic [31:0] addr);
`ifdef SUBWORD_ACCESS_EN
        int a;
        a = int'(addr[1:0]);
        if (f3[1:0] == 2'b00) return 4'(1 << a);
        if (f3[1:0] == 2'b01) return 4'(3 << a);
        return 4'hF;
`else
        return 4'hF;
`endif
    endfunction

    function automatic logic [31:0] mdlWdata(input logic [2:0] f3, input logic [31:0] wd);
`ifdef SUBWORD_ACCESS_EN
        if (f3 == 3'b000) return {4{wd[7:0]}};
        if (f3 == 3'b001) return {2{wd[15:0]}};
        return wd;
`else
        return wd;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || expStall) begin
            mRegWrite <= 1'b0; mResultSrc <= 2'b0; mAlu <= 32'b0;
            mRead <= 32'b0; mRd <= 5'b0; mPc <= 32'b0;
        end else begin
            mRegWrite  <= RegWriteM;
            mResultSrc <= ResultSrcM;
            mAlu       <= ALUResultM;
            mRead      <= (!MemWriteM && ResultSrcM == 2'b01) ?
                          mdlLoad(Funct3M, ALUResultM, dmem_rdata) : 32'b0;
            mRd        <= RdM;
            mPc        <= PCPlus4M;
        end
    end

    always @(negedge clk) begin
        if (checkEn && !rst) begin
            check("StallM", 32'(StallM), 32'(expStall));
            check("dmem_req", 32'(dmem_req), 32'(expReq));
            if (expReq) begin
                check("dmem_we", 32'(dmem_we), 32'(MemWriteM));
                check("dmem_addr", dmem_addr, {ALUResultM[31:2], 2'b00});
                check("dmem_be", 32'(dmem_be), 32'(mdlBe(Funct3M, ALUResultM)));
                if (MemWriteM)
                    check("dmem_wdata", dmem_wdata, mdlWdata(Funct3M, WriteDataM));
            end
            check("RegWriteW", 32'(RegWriteW), 32'(mRegWrite));
            check("ResultSrcW", 32'(ResultSrcW), 32'(mResultSrc));
            check("ALUResultW", ALUResultW, mAlu);
            check("ReadDataW", ReadDataW, mRead);
            check("RdW", 32'(RdW), 32'(mRd));
            check("PCPlus4W", PCPlus4W, mPc);
            if (StallM) stallSeen++;
            if (dmem_req) begin
                reqSeen++;
                lastBe <= dmem_be;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that retires the instruction.
    task automatic runInstr(input logic rw, input logic [1:0] rs, input logic mw,
                            input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                            input logic [4:0] rd, input logic [31:0] pc4,
                            input int gntAt, input int rvAt, input logic [31:0] rdata);
        logic st, ld;
        int cyc;
        bit done;
        st = mw;
        ld = !mw && (rs == 2'b01);
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3;
        ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
        cyc = 0;
        done = 0;
        while (!done) begin
            if (st) begin
                dmem_gnt = (cyc == gntAt); dmem_rvalid = 1'b0; dmem_rdata = $urandom;
                expReq = (cyc <= gntAt); expStall = (cyc < gntAt); done = (cyc >= gntAt);
            end else if (ld) begin
                dmem_gnt = (cyc == gntAt); dmem_rvalid = (cyc == rvAt);
                dmem_rdata = (cyc == rvAt) ? rdata : $urandom;
                expReq = (cyc <= gntAt); expStall = (cyc < rvAt); done = (cyc >= rvAt);
            end else begin
                // Stray rvalid while idle must not disturb anything.
                dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
                expReq = 1'b0; expStall = 1'b0; done = 1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    task automatic nop();
        runInstr(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; Funct3M = 3'b010;
        ALUResultM = 32'h40; WriteDataM = 32'h0; RdM = 5'd1; PCPlus4M = 32'h4;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        #1;
        check("reset_req", 32'(dmem_req), 32'h0);
        check("reset_RegWriteW", 32'(RegWriteW), 32'h0);
        check("reset_ReadDataW", ReadDataW, 32'h0);
        check("reset_RdW", 32'(RdW), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_req", 32'(dmem_req), 32'h0);
        RegWriteM = 1'b0; ResultSrcM = 2'b00; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        rst = 1'b0;
        checkEn = 1'b1;
        nop();

        // ALU op passes straight through
        stallSeen = 0; reqSeen = 0;
        runInstr(1'b1, 2'b00, 1'b0, 3'b000, 32'd7, 32'h0, 5'd5, 32'h44, 0, 0, 32'h5555);
        check("alu_RdW", 32'(RdW), 32'd5);
        check("alu_ALUResultW", ALUResultW, 32'd7);
        check("alu_ReadDataW", ReadDataW, 32'h0);
        check("alu_stall_cycles", 32'(stallSeen), 32'd0);
        check("alu_req_cycles", 32'(reqSeen), 32'd0);

        // Word load: gnt in cycle 0, rvalid in cycle 2
        stallSeen = 0;
        runInstr(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 5'd3, 32'h48, 0, 2, 32'hDEADBEEF);
        check("load_ReadDataW", ReadDataW, 32'hDEADBEEF);
        check("load_RegWriteW", 32'(RegWriteW), 32'd1);
        check("load_stall_cycles", 32'(stallSeen), 32'd2);

        // Store with gnt delayed 3 cycles
        stallSeen = 0; reqSeen = 0;
        runInstr(1'b0, 2'b00, 1'b1, 3'b010, 32'h200, 32'h12345678, 5'd0, 32'h4C, 3, 0, 32'h0);
        check("store_stall_cycles", 32'(stallSeen), 32'd3);
        check("store_req_cycles", 32'(reqSeen), 32'd4);

        // Zero-wait store
        stallSeen = 0; reqSeen = 0;
        runInstr(1'b0, 2'b00, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 5'd0, 32'h50, 0, 0, 32'h0);
        check("store0_stall_cycles", 32'(stallSeen), 32'd0);
        check("store0_req_cycles", 32'(reqSeen), 32'd1);

        // Load with delayed gnt and long wait for data, then back-to-back ALU op
        runInstr(1'b1, 2'b01, 1'b0, 3'b010, 32'h300, 32'h0, 5'd9, 32'h54, 2, 5, 32'h0BADF00D);
        check("load2_ReadDataW", ReadDataW, 32'h0BADF00D);
        runInstr(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd10, 32'h58, 0, 0, 32'h0);
        check("alu2_ReadDataW", ReadDataW, 32'h0);

        // Sub-word cases (or their word-only equivalents)
        runInstr(1'b1, 2'b01, 1'b0, 3'b000, 32'h103, 32'h0, 5'd4, 32'h5C, 0, 1, 32'h80AABBCC);
`ifdef SUBWORD_ACCESS_EN
        check("lb_ReadDataW", ReadDataW, 32'hFFFFFF80);
`else
        check("lb_word_ReadDataW", ReadDataW, 32'h80AABBCC);
`endif
        runInstr(1'b1, 2'b01, 1'b0, 3'b100, 32'h103, 32'h0, 5'd4, 32'h60, 1, 3, 32'h80AABBCC);
`ifdef SUBWORD_ACCESS_EN
        check("lbu_ReadDataW", ReadDataW, 32'h00000080);
`else
        check("lbu_word_ReadDataW", ReadDataW, 32'h80AABBCC);
`endif
        runInstr(1'b0, 2'b00, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 5'd0, 32'h64, 1, 0, 32'h0);
`ifdef SUBWORD_ACCESS_EN
        check("sh_be", 32'(lastBe), 32'h0000000C);
`else
        check("sh_word_be", 32'(lastBe), 32'h0000000F);
`endif
        nop();

        // Reset while waiting for read data; a late rvalid must be ignored
        checkEn = 1'b0;
        RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; Funct3M = 3'b010;
        ALUResultM = 32'h400; RdM = 5'd7; PCPlus4M = 32'h68;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0; expStall = 1'b1;
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        check("resp_wait_stall", 32'(StallM), 32'h1);
        check("resp_wait_req", 32'(dmem_req), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(dmem_req), 32'h0);
        check("midrst_RegWriteW", 32'(RegWriteW), 32'h0);
        check("midrst_RdW", 32'(RdW), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111;
        #1;
        // Back in IDLE the still-pending load is re-requested instead of consuming rvalid.
        check("post_rst_req", 32'(dmem_req), 32'h1);
        check("post_rst_stall", 32'(StallM), 32'h1);
        RegWriteM = 1'b0; ResultSrcM = 2'b00; RdM = 5'd0;
        expStall = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_RegWriteW", 32'(RegWriteW), 32'h0);
        check("post_rst_ReadDataW", ReadDataW, 32'h0);
        dmem_rvalid = 1'b0;
        checkEn = 1'b1;
        nop();
        runInstr(1'b1, 2'b00, 1'b0, 3'b000, 32'h77, 32'h0, 5'd12, 32'h6C, 0, 0, 32'h0);
        check("final_RdW", 32'(RdW), 32'd12);
        nop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
